// File: rtl/par_seri_tx_if.sv
// par_seri_tx_if -- parallel word handshake between a word source and par_seri_tx.
//   d_valid : source -> serializer, d carries a word to send
//   d       : source -> serializer, parallel data word (WIDTH bits)
//   d_ready : serializer -> source, a word can be accepted this cycle
// Modports: master (word source), slave (serializer).
interface par_seri_tx_if #(
  parameter int WIDTH = 4
) ();
  logic             d_valid;
  logic [WIDTH-1:0] d;
  logic             d_ready;

  modport master (output d_valid, output d, input d_ready);
  modport slave  (input d_valid, input d, output d_ready);
endinterface

// File: rtl/par_seri_tx.sv
// par_seri_tx -- parallel-to-serial transmitter with a single-entry holding
// buffer so back-to-back words stream without idle cycles.
// Ports:
//   ck    : clock, rising edge active
//   res   : asynchronous active-low reset
//   clr   : synchronous abort, drops the current frame and the holding buffer
//   din   : par_seri_tx_if.slave word handshake (d_valid, d, d_ready)
//   so    : serial data bit, 0 whenever en is 0
//   en    : so valid / downstream shift enable
//   done  : high during the cycle the last bit of a frame is presented
// Parameters: WIDTH (2..16), MSB_FIRST (1 = MSB first, 0 = LSB first).
// Optional feature: define PAR_SERI_PARITY_EN to append an even-parity bit
// to every frame.
module par_seri_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           ck,
  input  logic           res,
  input  logic           clr,
  par_seri_tx_if.slave   din,
  output logic           so,
  output logic           en,
  output logic           done
);

`ifdef PAR_SERI_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;        // bits still to present after the current one
`ifdef PAR_SERI_PARITY_EN
  logic             par;
`endif

  logic             accept;
  logic             last;
  logic             do_load;
  logic [WIDTH-1:0] ld_word;
  logic [WIDTH-1:0] ld_rest;
  logic             ld_bit;
  logic [WIDTH-1:0] sh_next;
  logic             nxt_bit;

  assign din.d_ready = ~hold_full;

  always_comb begin
    accept  = din.d_valid & ~hold_full;
    last    = (state == SHIFT) && (cnt == '0);
    // A frame starts from idle on accept, or at the last-bit edge from the
    // holding buffer (priority) or a same-edge accept, giving gapless frames.
    do_load = ((state == IDLE) && accept) || (last && (hold_full || accept));
    ld_word = hold_full ? hold : din.d;
    if (MSB_FIRST) begin
      ld_bit  = ld_word[WIDTH-1];
      ld_rest = ld_word << 1;
      nxt_bit = sh[WIDTH-1];
      sh_next = sh << 1;
    end else begin
      ld_bit  = ld_word[0];
      ld_rest = ld_word >> 1;
      nxt_bit = sh[0];
      sh_next = sh >> 1;
    end
`ifdef PAR_SERI_PARITY_EN
    if (cnt == CW'(1)) nxt_bit = par;
`endif
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      so        <= 1'b0;
      en        <= 1'b0;
      done      <= 1'b0;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
`ifdef PAR_SERI_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (clr) begin
      state     <= IDLE;
      so        <= 1'b0;
      en        <= 1'b0;
      done      <= 1'b0;
      sh        <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else if (do_load) begin
      state     <= SHIFT;
      so        <= ld_bit;
      en        <= 1'b1;
      done      <= 1'b0;
      sh        <= ld_rest;
      cnt       <= CW'(FL - 1);
      hold_full <= 1'b0;
`ifdef PAR_SERI_PARITY_EN
      par       <= ^ld_word;
`endif
    end else if (last) begin
      state <= IDLE;
      so    <= 1'b0;
      en    <= 1'b0;
      done  <= 1'b0;
    end else if (state == SHIFT) begin
      so   <= nxt_bit;
      sh   <= sh_next;
      cnt  <= cnt - CW'(1);
      done <= (cnt == CW'(1));
      if (accept) begin
        hold      <= din.d;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_par_seri_tx.sv
// tb_par_seri_tx -- directed self-checking bench for par_seri_tx.
// Two instances: u (MSB_FIRST=1) and ul (MSB_FIRST=0). Inputs change #1 after
// a rising edge; outputs are checked in the same window.
module tb_par_seri_tx;
  logic ck  = 1'b0;
  logic res = 1'b0;
  logic clr = 1'b0;
  logic so, en, done;
  logic so_l, en_l, done_l;
  logic [3:0] q;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  par_seri_tx_if #(.WIDTH(4)) bus ();
  par_seri_tx_if #(.WIDTH(4)) bus_l ();

  par_seri_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u (
    .ck(ck), .res(res), .clr(clr), .din(bus.slave),
    .so(so), .en(en), .done(done)
  );

  par_seri_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) ul (
    .ck(ck), .res(res), .clr(1'b0), .din(bus_l.slave),
    .so(so_l), .en(en_l), .done(done_l)
  );

  always #5 ck = ~ck;

  // downstream serial-in/parallel-out stage
  always @(posedge ck) if (en) q <= {q[2:0], so};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic exp_so, input logic exp_done);
    chk({tag, ".en"}, {7'd0, en}, 8'd1);
    chk({tag, ".so"}, {7'd0, so}, {7'd0, exp_so});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, exp_done});
  endtask

  task automatic step(input string tag, input logic exp_so, input logic exp_done);
    chk_bit(tag, exp_so, exp_done);
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".en"}, {7'd0, en}, 8'd0);
    chk({tag, ".so"}, {7'd0, so}, 8'd0);
    chk({tag, ".done"}, {7'd0, done}, 8'd0);
    chk({tag, ".rdy"}, {7'd0, bus.d_ready}, 8'd1);
  endtask

  initial begin
    bus.d_valid   = 1'b0;
    bus.d         = '0;
    bus_l.d_valid = 1'b0;
    bus_l.d       = '0;

    // reset state
    #3;
    chk_idle("reset");
    tick();
    res = 1'b1;
    tick();
    chk_idle("post_reset");

    // single frame 1011 on both instances
    bus.d = 4'b1011;   bus.d_valid = 1'b1;
    bus_l.d = 4'b1011; bus_l.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0; bus_l.d_valid = 1'b0;
    chk("lsb0", {7'd0, so_l}, 8'd1);
    step("a0", 1'b1, 1'b0);
    chk("lsb1", {7'd0, so_l}, 8'd1);
    step("a1", 1'b0, 1'b0);
    chk("lsb2", {7'd0, so_l}, 8'd0);
    step("a2", 1'b1, 1'b0);
    chk("lsb3", {7'd0, so_l}, 8'd1);
`ifdef PAR_SERI_PARITY_EN
    chk("lsb3.done", {7'd0, done_l}, 8'd0);
    step("a3", 1'b1, 1'b0);
    chk("lsbp", {7'd0, so_l}, 8'd1);
    chk("lsbp.done", {7'd0, done_l}, 8'd1);
    step("ap", 1'b1, 1'b1);
    chk("a.q", {4'd0, q}, 8'b0111);
`else
    chk("lsb3.done", {7'd0, done_l}, 8'd1);
    step("a3", 1'b1, 1'b1);
    chk("a.q", {4'd0, q}, 8'b1011);
`endif
    chk_idle("a_end");
    chk("lsb_end.en", {7'd0, en_l}, 8'd0);

    // back-to-back: 1011 then 0110 through the holding buffer
    bus.d = 4'b1011; bus.d_valid = 1'b1;
    tick();
    bus.d = 4'b0110;
    chk("b.rdy_empty", {7'd0, bus.d_ready}, 8'd1);
    chk_bit("b0", 1'b1, 1'b0);
    tick();
    bus.d_valid = 1'b0;
    chk("b.rdy_full", {7'd0, bus.d_ready}, 8'd0);
    step("b1", 1'b0, 1'b0);
    step("b2", 1'b1, 1'b0);
`ifdef PAR_SERI_PARITY_EN
    step("b3", 1'b1, 1'b0);
    step("bp", 1'b1, 1'b1);
`else
    step("b3", 1'b1, 1'b1);
`endif
    chk("b.rdy_drained", {7'd0, bus.d_ready}, 8'd1);
    step("b4", 1'b0, 1'b0);
    step("b5", 1'b1, 1'b0);
    step("b6", 1'b1, 1'b0);
`ifdef PAR_SERI_PARITY_EN
    step("b7", 1'b0, 1'b0);
    step("bq", 1'b0, 1'b1);
`else
    step("b7", 1'b0, 1'b1);
`endif
    chk_idle("b_end");

    // accept on the last-bit edge with an empty buffer loads directly
    bus.d = 4'b1100; bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    step("c0", 1'b1, 1'b0);
    step("c1", 1'b1, 1'b0);
`ifdef PAR_SERI_PARITY_EN
    step("c2", 1'b0, 1'b0);
    step("c3", 1'b0, 1'b0);
    chk_bit("cp", 1'b0, 1'b1);
`else
    step("c2", 1'b0, 1'b0);
    chk_bit("c3", 1'b0, 1'b1);
`endif
    bus.d = 4'b0011; bus.d_valid = 1'b1;
    chk("c.rdy_last", {7'd0, bus.d_ready}, 8'd1);
    tick();
    bus.d_valid = 1'b0;
    step("c4", 1'b0, 1'b0);
    step("c5", 1'b0, 1'b0);
    step("c6", 1'b1, 1'b0);
`ifdef PAR_SERI_PARITY_EN
    step("c7", 1'b1, 1'b0);
    step("cq", 1'b0, 1'b1);
`else
    step("c7", 1'b1, 1'b1);
`endif
    chk_idle("c_end");

    // clr on the 2nd bit of 1111 while d_valid stays high
    bus.d = 4'b1111; bus.d_valid = 1'b1;
    tick();
    chk_bit("d0", 1'b1, 1'b0);
    tick();
    chk_bit("d1", 1'b1, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.d_valid = 1'b0;
    chk_idle("d_clr");
    tick();
    chk_idle("d_after");

    // asynchronous reset mid-frame, then 0001
    bus.d = 4'b1111; bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    chk_bit("e0", 1'b1, 1'b0);
    tick();
    #2;
    res = 1'b0;
    #1;
    chk_idle("e_rst");
    tick();
    res = 1'b1;
    tick();
    chk_idle("e_rel");
    bus.d = 4'b0001; bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    step("f0", 1'b0, 1'b0);
    step("f1", 1'b0, 1'b0);
    step("f2", 1'b0, 1'b0);
`ifdef PAR_SERI_PARITY_EN
    step("f3", 1'b1, 1'b0);
    step("fp", 1'b1, 1'b1);
`else
    step("f3", 1'b1, 1'b1);
`endif
    chk_idle("f_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
